// File: rtl/up_param_pkg.sv
// up_param_pkg: opcode values and FSM state encoding shared by the up_core_param files.
package up_param_pkg;
    localparam logic [3:0] OP_LDA  = 4'h0;
    localparam logic [3:0] OP_STA  = 4'h1;
    localparam logic [3:0] OP_ADD  = 4'h2;
    localparam logic [3:0] OP_SUB  = 4'h3;
    localparam logic [3:0] OP_AND  = 4'h4;
    localparam logic [3:0] OP_OR   = 4'h5;
    localparam logic [3:0] OP_XOR  = 4'h6;
    localparam logic [3:0] OP_LDI  = 4'h7;
    localparam logic [3:0] OP_IN   = 4'h8;
    localparam logic [3:0] OP_OUT  = 4'h9;
    localparam logic [3:0] OP_JMP  = 4'hA;
    localparam logic [3:0] OP_JZ   = 4'hB;
    localparam logic [3:0] OP_JPOS = 4'hC;
    localparam logic [3:0] OP_JC   = 4'hD;
    localparam logic [3:0] OP_SHF  = 4'hE;
    localparam logic [3:0] OP_HALT = 4'hF;
    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_IN_WAIT, S_HALTED} state_t;
endpackage

// File: rtl/up_param_ram.sv
// up_param_ram: 2**ADDR_W x DATA_W program/data RAM, one sync write port, two async read ports.
// Ports: clk; we/waddr/wdata write; raddr0/rdata0 and raddr1/rdata1 async reads.
module up_param_ram #(
    parameter int DATA_W = 12,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr0,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1
);
    logic [DATA_W-1:0] mem [2**ADDR_W];
    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;
    assign rdata0 = mem[raddr0];
    assign rdata1 = mem[raddr1];
endmodule

// File: rtl/up_core_param.sv
// up_core_param: parametrised accumulator CPU, fetch/decode/execute FSM with carry, IN/OUT and load port.
// Ports: CLOCK, RESET (sync, active-high); Enter/Input operator input; Load_en/Load_addr/Load_data
// program load (honoured only in reset or halt); In_ready, Out_valid, Output, Halt status/outputs.
module up_core_param import up_param_pkg::*; #(
    parameter int DATA_W = 12,
    parameter int ADDR_W = 8
) (
    input  logic              CLOCK,
    input  logic              RESET,
    input  logic              Enter,
    input  logic [DATA_W-1:0] Input,
    input  logic              Load_en,
    input  logic [ADDR_W-1:0] Load_addr,
    input  logic [DATA_W-1:0] Load_data,
    output logic              In_ready,
    output logic              Out_valid,
    output logic [DATA_W-1:0] Output,
    output logic              Halt
);
    state_t            state, state_nx;
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] ir, a, fetch_word, m;
    logic              c, enter_q, rise, load_ok, we;
    logic [3:0]        op;
    logic [ADDR_W-1:0] opr;

    assign op      = ir[DATA_W-1 -: 4];
    assign opr     = ir[ADDR_W-1:0];
    assign rise    = Enter & ~enter_q;
    assign load_ok = Load_en & (RESET | Halt);
    // a core store is suppressed while RESET is high so an abandoned STA never lands
    assign we      = load_ok | (~RESET & state == S_EXEC & op == OP_STA);

    up_param_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
        .clk(CLOCK),
        .we(we),
        .waddr(load_ok ? Load_addr : opr),
        .wdata(load_ok ? Load_data : a),
        .raddr0(pc),
        .raddr1(opr),
        .rdata0(fetch_word),
        .rdata1(m)
    );

    always_ff @(posedge CLOCK)
        state <= RESET ? S_FETCH : state_nx;

    always_comb begin
        state_nx = state;
        case (state)
            S_FETCH:   state_nx = S_DECODE;
            S_DECODE:  state_nx = op == OP_IN ? S_IN_WAIT : S_EXEC;
            S_EXEC:    state_nx = op == OP_HALT ? S_HALTED : S_FETCH;
            S_IN_WAIT: state_nx = rise ? S_FETCH : S_IN_WAIT;
            default:   state_nx = S_HALTED;
        endcase
    end

    always_comb begin
        In_ready = state == S_IN_WAIT;
        Halt     = state == S_HALTED;
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            pc        <= '0;
            ir        <= '0;
            a         <= '0;
            c         <= 1'b0;
            enter_q   <= 1'b0;
            Output    <= '0;
            Out_valid <= 1'b0;
        end else begin
            enter_q   <= Enter;
            Out_valid <= 1'b0;
            if (state == S_FETCH) begin
                ir <= fetch_word;
                pc <= pc + ADDR_W'(1);
            end
            if (state == S_IN_WAIT && rise) a <= Input;
            if (state == S_EXEC)
                case (op)
                    OP_LDA:  a <= m;
                    OP_ADD:  {c, a} <= {1'b0, a} + {1'b0, m};
                    OP_SUB:  {c, a} <= {1'b0, a} + {1'b0, ~m} + {{DATA_W{1'b0}}, 1'b1};
                    OP_AND:  a <= a & m;
                    OP_OR:   a <= a | m;
                    OP_XOR:  a <= a ^ m;
                    OP_LDI:  a <= {{(DATA_W-ADDR_W){1'b0}}, opr};
                    OP_OUT:  begin Output <= a; Out_valid <= 1'b1; end
                    OP_JMP:  pc <= opr;
                    OP_JZ:   if (a == '0) pc <= opr;
                    OP_JPOS: if (!a[DATA_W-1]) pc <= opr;
                    OP_JC:   if (c) pc <= opr;
                    OP_SHF:  if (opr[0]) {a, c} <= {1'b0, a}; else {c, a} <= {a, 1'b0};
                    default: ;
                endcase
        end
    end
endmodule

// File: tb/tb_up_core_param.sv
// tb_up_core_param: directed and random-program checks of up_core_param against an ISA-level model.
module tb_up_core_param;
    logic        CLOCK = 0, RESET = 1, Enter = 0, Load_en = 0;
    logic [11:0] Input = 0, Load_data = 0, Output;
    logic [7:0]  Load_addr = 0;
    logic        In_ready, Out_valid, Halt;
    int          checks = 0, errors = 0;
    int          img [256];
    int          out_q [$], exp_q [$];
    int          mhalt, mexec;

    up_core_param #(.DATA_W(12), .ADDR_W(8)) dut (
        .CLOCK(CLOCK), .RESET(RESET), .Enter(Enter), .Input(Input),
        .Load_en(Load_en), .Load_addr(Load_addr), .Load_data(Load_data),
        .In_ready(In_ready), .Out_valid(Out_valid), .Output(Output), .Halt(Halt)
    );

    always #5 CLOCK = ~CLOCK;
    always @(negedge CLOCK) if (Out_valid) out_q.push_back(int'(Output));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLOCK);
        #1;
    endtask

    task automatic wr(input int ad, input int d);
        Load_en = 1;
        Load_addr = ad[7:0];
        Load_data = d[11:0];
        tick;
        Load_en = 0;
    endtask

    task automatic load_all;
        RESET = 1;
        for (int i = 0; i < 256; i++) wr(i, img[i]);
        out_q.delete();
        chk("rst_output", Output, 0);
        chk("rst_out_valid", Out_valid, 0);
        chk("rst_halt", Halt, 0);
        chk("rst_in_ready", In_ready, 0);
    endtask

    task automatic clear_img;
        foreach (img[i]) img[i] = 0;
    endtask

    task automatic wait_halt(input string tag);
        for (int i = 0; i < 2000 && !Halt; i++) tick;
        chk({tag, "_halt"}, Halt, 1);
    endtask

    task automatic cmp_out(input string tag);
        @(negedge CLOCK);
        #1;
        chk({tag, "_nout"}, out_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < out_q.size(); i++)
            chk($sformatf("%s_out%0d", tag, i), out_q[i], exp_q[i]);
    endtask

    // instruction-set model: executes up to k instructions of img, recording OUT values
    task automatic model(input int k);
        int mem [256];
        int pc, a, c, w, op, opr, m;
        pc = 0; a = 0; c = 0; mhalt = 0; mexec = 0;
        exp_q.delete();
        foreach (mem[i]) mem[i] = img[i];
        while (!mhalt && mexec < k) begin
            w = mem[pc]; pc = (pc + 1) % 256;
            op = w / 256; opr = w % 256; m = mem[opr];
            mexec++;
            case (op)
                0:  a = m;
                1:  mem[opr] = a;
                2:  begin a = a + m; c = a / 4096; a = a % 4096; end
                3:  begin c = (a >= m) ? 1 : 0; a = (a - m + 4096) % 4096; end
                4:  a = a & m;
                5:  a = a | m;
                6:  a = a ^ m;
                7:  a = opr;
                9:  exp_q.push_back(a);
                10: pc = opr;
                11: if (a == 0) pc = opr;
                12: if (a < 2048) pc = opr;
                13: if (c == 1) pc = opr;
                14: if (opr % 2 == 1) begin c = a % 2; a = a / 2; end
                    else begin c = a / 2048; a = (a * 2) % 4096; end
                15: mhalt = 1;
                default: ;
            endcase
        end
    endtask

    initial begin
        // basic program
        clear_img;
        img[0] = 'h014; img[1] = 'h215; img[2] = 'h900; img[3] = 'hF00; img[20] = 5; img[21] = 7;
        load_all;
        RESET = 0;
        repeat (8) tick;
        chk("b_ov8", Out_valid, 0);
        tick;
        chk("b_ov9", Out_valid, 1);
        chk("b_out9", Output, 'h00C);
        tick;
        chk("b_ov10", Out_valid, 0);
        tick;
        chk("b_halt11", Halt, 0);
        tick;
        chk("b_halt12", Halt, 1);
        repeat (10) tick;
        chk("b_out_hold", Output, 'h00C);
        chk("b_halt_hold", Halt, 1);
        exp_q = '{'h00C};
        cmp_out("b");

        // carry and branches
        clear_img;
        img[0] = 'h040; img[1] = 'h241; img[2] = 'h900; img[3] = 'hB05; img[4] = 'hF00;
        img[5] = 'hD07; img[6] = 'hF00; img[7] = 'h705; img[8] = 'h342; img[9] = 'h900;
        img[10] = 'hC20; img[11] = 'hD20; img[12] = 'h043; img[13] = 'hE00; img[14] = 'h900;
        img[15] = 'hD11; img[16] = 'hF00; img[17] = 'h72A; img[18] = 'h900; img[19] = 'hF00;
        img['h20] = 'h777; img['h21] = 'h900; img['h22] = 'hF00;
        img['h40] = 'hFFF; img['h41] = 'h001; img['h42] = 'h007; img['h43] = 'h800;
        load_all;
        RESET = 0;
        wait_halt("cb");
        exp_q = '{'h000, 'hFFE, 'h000, 'h02A};
        cmp_out("cb");

        // Enter held across IN entry, rise before IN discarded
        clear_img;
        img[0] = 'h800; img[1] = 'h900; img[2] = 'hF00;
        Enter = 1; Input = 'h123;
        load_all;
        RESET = 0;
        tick;
        chk("e_rdy1", In_ready, 0);
        tick;
        chk("e_rdy2", In_ready, 1);
        repeat (5) tick;
        chk("e_rdy_held", In_ready, 1);
        Enter = 0;
        tick;
        chk("e_rdy_low", In_ready, 1);
        Input = 'h0A5; Enter = 1;
        tick;
        chk("e_rdy_done", In_ready, 0);
        wait_halt("e");
        Enter = 0;
        exp_q = '{'h0A5};
        cmp_out("e");

        // PC wrap from FF to 00
        clear_img;
        img[0] = 'hB10; img[1] = 'h900; img[2] = 'hF00; img['h10] = 'hAFF; img['hFF] = 'h703;
        load_all;
        RESET = 0;
        repeat (17) tick;
        chk("w_halt17", Halt, 0);
        tick;
        chk("w_halt18", Halt, 1);
        exp_q = '{'h003};
        cmp_out("w");

        // reset while waiting in IN
        clear_img;
        img[0] = 'h711; img[1] = 'h900; img[2] = 'h800; img[3] = 'h900; img[4] = 'hF00;
        load_all;
        RESET = 0;
        repeat (8) tick;
        chk("r_rdy", In_ready, 1);
        RESET = 1;
        tick;
        chk("r_rdy_rst", In_ready, 0);
        chk("r_pc_rst", dut.pc, 0);
        chk("r_a_rst", dut.a, 0);
        RESET = 0;
        repeat (7) tick;
        chk("r_rdy7", In_ready, 0);
        tick;
        chk("r_rdy8", In_ready, 1);
        Input = 'h03C; Enter = 1;
        tick;
        wait_halt("r");
        Enter = 0;
        exp_q = '{'h011, 'h011, 'h03C};
        cmp_out("r");

        // load port gating
        clear_img;
        img[0] = 'h030; img[1] = 'h900; img[2] = 'h030; img[3] = 'h900; img[4] = 'hF00; img['h30] = 'h111;
        load_all;
        RESET = 0;
        tick;
        Load_en = 1; Load_addr = 'h30; Load_data = 'hABC;
        repeat (4) tick;
        Load_en = 0;
        wait_halt("lg");
        exp_q = '{'h111, 'h111};
        cmp_out("lg");
        wr('h30, 'h222);
        tick;
        RESET = 1;
        tick;
        out_q.delete();
        RESET = 0;
        wait_halt("lh");
        exp_q = '{'h222, 'h222};
        cmp_out("lh");

        // random programs against the model
        for (int p = 0; p < 10; p++) begin
            foreach (img[i]) begin
                int w;
                w = int'($urandom_range(0, 4095));
                if (w / 256 == 8) w = w + 256;
                if ($urandom_range(0, 11) == 0) w = 'hF00 | (w % 256);
                img[i] = w;
            end
            load_all;
            model(150);
            RESET = 0;
            if (mhalt == 1) begin
                repeat (3 * mexec - 1) tick;
                chk($sformatf("rnd%0d_prehalt", p), Halt, 0);
                tick;
                chk($sformatf("rnd%0d_halt", p), Halt, 1);
            end else begin
                repeat (3 * 150) tick;
                chk($sformatf("rnd%0d_run", p), Halt, 0);
            end
            cmp_out($sformatf("rnd%0d", p));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
